// File: rtl/vec_mem_arbiter_if.sv
// Shared bus between the three requesters, the arbiter and the sram byte controller.
// Pure wiring bundle; no logic, no latency.
// Handshake is level request / one-cycle ack on the requester side, strobe / ready pulse on the sram side.
interface vec_mem_arbiter_if #(
  parameter int AW = 25
);
  // loader (ioctl) requester
  logic          ldr_mode;
  logic          ldr_req;
  logic [AW-1:0] ldr_addr;
  logic [7:0]    ldr_din;
  logic          ldr_ack;
  // video fetch requester
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  // cpu requester
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_ack;
  // shared read data back to requesters
  logic [7:0]    rdata;
  // sram side
  logic          mem_rd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          mem_ready;

  // arbiter view
  modport slave (
    input  ldr_mode, ldr_req, ldr_addr, ldr_din,
    output ldr_ack,
    input  vid_req, vid_addr,
    output vid_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_ack,
    output rdata,
    output mem_rd, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ready
  );

  // requester / sram environment view
  modport master (
    output ldr_mode, ldr_req, ldr_addr, ldr_din,
    input  ldr_ack,
    output vid_req, vid_addr,
    input  vid_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_ack,
    input  rdata,
    input  mem_rd, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/vec_mem_arbiter.sv
// Single-port sram scheduler for loader, video and cpu; one op in flight, video ahead of cpu with a starvation guard.
// Latency: req seen in IDLE at cycle N -> strobe at N+1 -> ack one cycle after mem_ready.
// Backpressure: requesters hold req until ack; no new grant in an ack cycle. Optional stats ports under VEC_ARB_STATS_EN.
module vec_mem_arbiter #(
  parameter int AW         = 25,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  vec_mem_arbiter_if.slave bus
`ifdef VEC_ARB_STATS_EN
  ,
  output logic [15:0]      stat_cpu_max_wait,
  output logic [15:0]      stat_vid_grants
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LDR, OWN_VID, OWN_CPU} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_q, state_d;
  owner_t        owner_q, grant;
  logic          we_q;
  logic [3:0]    starve_q;
  logic          starve_full;
  logic          ack_busy;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_din;
  logic          sel_we;

  assign starve_full = (starve_q == STARVE_LIM);
  // The acked requester still holds req during its ack cycle, so nothing is granted then.
  assign ack_busy    = bus.ldr_ack | bus.vid_ack | bus.cpu_ack;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Arbitration in IDLE, sequencing IDLE -> ISSUE -> WAIT -> IDLE, and request mux.
  always_comb begin
    state_d  = state_q;
    grant    = OWN_NONE;
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ack_busy) begin
          if (bus.ldr_mode) begin
            if (bus.ldr_req) grant = OWN_LDR;
          end else if (bus.vid_req && !(bus.cpu_req && starve_full)) begin
            grant = OWN_VID;
          end else if (bus.cpu_req) begin
            grant = OWN_CPU;
          end
        end
        if (grant != OWN_NONE) state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (grant)
      OWN_LDR: begin
        sel_addr = bus.ldr_addr;
        sel_din  = bus.ldr_din;
        sel_we   = 1'b1;
      end
      OWN_VID: begin
        sel_addr = bus.vid_addr;
      end
      OWN_CPU: begin
        sel_addr = bus.cpu_addr;
        sel_din  = bus.cpu_din;
        sel_we   = bus.cpu_we;
      end
      default: ;
    endcase
  end

  // Latch the granted op, strobe during ISSUE, and return ack/read data on completion.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      we_q         <= 1'b0;
      bus.mem_rd   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.ldr_ack  <= 1'b0;
      bus.vid_ack  <= 1'b0;
      bus.cpu_ack  <= 1'b0;
      bus.rdata    <= '0;
    end else begin
      bus.mem_rd  <= 1'b0;
      bus.mem_we  <= 1'b0;
      bus.ldr_ack <= 1'b0;
      bus.vid_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      if (grant != OWN_NONE) begin
        owner_q      <= grant;
        we_q         <= sel_we;
        bus.mem_addr <= sel_addr;
        bus.mem_din  <= sel_din;
        bus.mem_rd   <= !sel_we;
        bus.mem_we   <= sel_we;
      end
      if (state_q == WAIT && bus.mem_ready) begin
        case (owner_q)
          OWN_LDR: bus.ldr_ack <= 1'b1;
          OWN_VID: bus.vid_ack <= 1'b1;
          OWN_CPU: bus.cpu_ack <= 1'b1;
          default: ;
        endcase
        if (!we_q) bus.rdata <= bus.mem_dout;
      end
    end
  end

  // Count video grants that bypass a waiting cpu; cleared once the cpu is served or stops asking.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant == OWN_CPU || !bus.cpu_req) starve_q <= '0;
      else if (grant == OWN_VID && !starve_full) starve_q <= starve_q + 4'd1;
    end
  end

`ifdef VEC_ARB_STATS_EN
  logic [15:0] cpu_wait_cnt;

  // Track the longest cpu wait (cycles req high before ack) and total video grants.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_wait_cnt      <= '0;
      stat_cpu_max_wait <= '0;
      stat_vid_grants   <= '0;
    end else begin
      if (bus.cpu_ack) begin
        if (cpu_wait_cnt > stat_cpu_max_wait) stat_cpu_max_wait <= cpu_wait_cnt;
        cpu_wait_cnt <= '0;
      end else if (bus.cpu_req) begin
        if (cpu_wait_cnt != 16'hFFFF) cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
      end else begin
        cpu_wait_cnt <= '0;
      end
      if (grant == OWN_VID) stat_vid_grants <= stat_vid_grants + 16'd1;
    end
  end
`endif

endmodule
